// File: rtl/param_cpu_pkg.sv
// Shared opcodes, FSM state encoding and width helpers for param_cpu and its ALU.
// PARAM_CPU_CARRY_EN enables the carry flag and the JC opcode.
package param_cpu_pkg;

`ifdef PARAM_CPU_CARRY_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_JC   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_HALT   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_EXEC   = 2'd3
  } state_e;

  // Instruction layout is [opcode(4) | rd | rs | imm(DATA_W)].
  function automatic int instr_w(input int data_w, input int ra_w);
    return 4 + 2 * ra_w + data_w;
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_NOP, OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_MOV, OP_JMP, OP_JZ, OP_HALT: return 1'b1;
      OP_JC:                          return CARRY_EN;
      default:                        return 1'b0;
    endcase
  endfunction

  // Opcodes that write rd and update zero_flag.
  function automatic logic op_writes_reg(input logic [3:0] op);
    case (op)
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/param_cpu_alu.sv
// Combinational ALU: LDI/MOV pass operand b through, ADD/SUB report carry/borrow.
module param_cpu_alu
  import param_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Zero-extended so the top bit is the carry-out (ADD) or borrow (SUB).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = a;
    carry  = 1'b0;
    case (op)
      OP_LDI: result = b;
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_MOV: result = b;
      default: result = a;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/param_cpu.sv
// Three-cycle multicycle CPU (FETCH/DECODE/EXECUTE) with HALT-mode programming port.
// Define PARAM_CPU_CARRY_EN to enable carry_flag and the JC opcode.
module param_cpu
  import param_cpu_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int NUM_REGS   = 4,
  parameter  int IMEM_DEPTH = 16,
  localparam int PC_W       = $clog2(IMEM_DEPTH),
  localparam int RA_W       = $clog2(NUM_REGS),
  localparam int INSTR_W    = instr_w(DATA_W, RA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [RA_W-1:0]    dbg_sel,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instruction,
  output logic               halted,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               illegal
);

  state_e state_q, state_d;

  logic [INSTR_W-1:0] imem [IMEM_DEPTH];
  logic [DATA_W-1:0]  regs [NUM_REGS];

  logic [3:0]        opcode;
  logic [RA_W-1:0]   rd_f, rs_f;
  logic [DATA_W-1:0] imm_f;

  logic [3:0]        op_p1;
  logic [RA_W-1:0]   rd_p1;
  logic [DATA_W-1:0] a_p1, b_p1;
  logic [PC_W-1:0]   jmp_p1;

  logic [DATA_W-1:0] alu_result;
  logic              alu_zero, alu_carry;
  logic [PC_W-1:0]   pc_inc;

  assign opcode = instruction[INSTR_W-1 -: 4];
  assign rd_f   = instruction[INSTR_W-5 -: RA_W];
  assign rs_f   = instruction[DATA_W +: RA_W];
  assign imm_f  = instruction[DATA_W-1:0];
  assign pc_inc = pc + PC_W'(1);

  assign halted   = (state_q == S_HALT);
  assign illegal  = (state_q == S_EXEC) && !op_legal(op_p1);
  assign dbg_data = regs[dbg_sel];

  // Control FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_HALT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALT:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (op_p1 == OP_HALT) ? S_HALT : S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  // Program port; imem is deliberately untouched by rst.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_HALT)) imem[prog_addr] <= prog_data;
  end

  // DECODE -> p1: operand latches (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (state_q == S_DECODE) begin
      op_p1  <= opcode;
      rd_p1  <= rd_f;
      a_p1   <= regs[rd_f];
      b_p1   <= (opcode == OP_LDI) ? imm_f : regs[rs_f];
      jmp_p1 <= imm_f[PC_W-1:0];
    end
  end

  param_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_p1),
    .a      (a_p1),
    .b      (b_p1),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

`ifdef PARAM_CPU_CARRY_EN
  logic carry_q;
  assign carry_flag = carry_q;
`else
  logic unused_alu_carry;
  assign unused_alu_carry = alu_carry;
  assign carry_flag = 1'b0;
`endif

  // FETCH / EXECUTE: architectural state, cleared by rst so an aborted EXECUTE writes nothing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= '0;
      instruction <= '0;
      zero_flag   <= 1'b0;
`ifdef PARAM_CPU_CARRY_EN
      carry_q     <= 1'b0;
`endif
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state_q)
        S_HALT:  if (start) pc <= '0;
        S_FETCH: instruction <= imem[pc];
        S_EXEC: begin
          pc <= pc_inc;
          if (op_writes_reg(op_p1)) begin
            regs[rd_p1] <= alu_result;
            zero_flag   <= alu_zero;
          end
`ifdef PARAM_CPU_CARRY_EN
          if ((op_p1 == OP_ADD) || (op_p1 == OP_SUB)) carry_q <= alu_carry;
          if ((op_p1 == OP_JC) && carry_q) pc <= jmp_p1;
`endif
          // Later assignments override the default increment.
          case (op_p1)
            OP_JMP:  pc <= jmp_p1;
            OP_JZ:   if (zero_flag) pc <= jmp_p1;
            OP_HALT: pc <= pc;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_param_cpu.sv
// Directed table-driven bench for param_cpu (defaults DATA_W=8, NUM_REGS=4, IMEM_DEPTH=16).
module tb_param_cpu;

  logic        clk = 1'b0;
  logic        rst, start, prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;
  logic [3:0]  pc;
  logic [15:0] instruction;
  logic        halted, zero_flag, carry_flag, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] HLT = 16'hF000;
  localparam logic [15:0] NOP = 16'h0000;
`ifdef PARAM_CPU_CARRY_EN
  localparam logic CEN = 1'b1;
`else
  localparam logic CEN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0][15:0] prog;
    logic [3:0][7:0]  regs;
    logic [3:0]       pc;
    logic             z;
    logic             c;
    logic [7:0]       cyc;
  } vec_t;

  localparam int NV = 9;
  vec_t tv [NV];

  param_cpu dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data),
    .pc          (pc),
    .instruction (instruction),
    .halted      (halted),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic load(input logic [15:0][15:0] img);
    for (int w = 0; w < 16; w++) begin
      prog_we   = 1'b1;
      prog_addr = 4'(w);
      prog_data = img[w];
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_regs(input string tag, input logic [3:0][7:0] exp);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      check($sformatf("%s r%0d", tag, r), 32'(dbg_data), 32'(exp[r]));
    end
  endtask

  initial begin
    logic [15:0][15:0] img;
    int cyc;
    int ill_cnt, ill_at;

    rst = 1'b1; start = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; dbg_sel = '0;

    // T0 ADD 5+3
    tv[0].prog = {8{HLT}};
    tv[0].prog[0] = ins(4'h1, 2'd0, 2'd0, 8'h05);
    tv[0].prog[1] = ins(4'h1, 2'd1, 2'd0, 8'h03);
    tv[0].prog[2] = ins(4'h2, 2'd0, 2'd1, 8'h00);
    tv[0].regs = {8'h00, 8'h00, 8'h03, 8'h08};
    tv[0].pc = 4'd3; tv[0].z = 1'b0; tv[0].c = 1'b0; tv[0].cyc = 8'd12;
    // T1 ADD overflow FF+1
    tv[1].prog = {8{HLT}};
    tv[1].prog[0] = ins(4'h1, 2'd0, 2'd0, 8'hFF);
    tv[1].prog[1] = ins(4'h1, 2'd1, 2'd0, 8'h01);
    tv[1].prog[2] = ins(4'h2, 2'd0, 2'd1, 8'h00);
    tv[1].regs = {8'h00, 8'h00, 8'h01, 8'h00};
    tv[1].pc = 4'd3; tv[1].z = 1'b1; tv[1].c = CEN; tv[1].cyc = 8'd12;
    // T2 SUB 3-5 borrows
    tv[2].prog = {8{HLT}};
    tv[2].prog[0] = ins(4'h1, 2'd0, 2'd0, 8'h03);
    tv[2].prog[1] = ins(4'h1, 2'd1, 2'd0, 8'h05);
    tv[2].prog[2] = ins(4'h3, 2'd0, 2'd1, 8'h00);
    tv[2].regs = {8'h00, 8'h00, 8'h05, 8'hFE};
    tv[2].pc = 4'd3; tv[2].z = 1'b0; tv[2].c = CEN; tv[2].cyc = 8'd12;
    // T3 AND / MOV / OR / LDI 0
    tv[3].prog = {8{HLT}};
    tv[3].prog[0] = ins(4'h1, 2'd0, 2'd0, 8'hF0);
    tv[3].prog[1] = ins(4'h1, 2'd1, 2'd0, 8'h3C);
    tv[3].prog[2] = ins(4'h4, 2'd0, 2'd1, 8'h00);
    tv[3].prog[3] = ins(4'h6, 2'd2, 2'd0, 8'h00);
    tv[3].prog[4] = ins(4'h5, 2'd2, 2'd1, 8'h00);
    tv[3].prog[5] = ins(4'h1, 2'd3, 2'd0, 8'h00);
    tv[3].regs = {8'h00, 8'h3C, 8'h3C, 8'h30};
    tv[3].pc = 4'd6; tv[3].z = 1'b1; tv[3].c = 1'b0; tv[3].cyc = 8'd21;
    // T4 JZ taken
    tv[4].prog = {8{HLT}};
    tv[4].prog[0] = ins(4'h1, 2'd0, 2'd0, 8'h00);
    tv[4].prog[1] = ins(4'h8, 2'd0, 2'd0, 8'h06);
    tv[4].prog[2] = ins(4'h1, 2'd1, 2'd0, 8'h07);
    tv[4].regs = {8'h00, 8'h00, 8'h00, 8'h00};
    tv[4].pc = 4'd6; tv[4].z = 1'b1; tv[4].c = 1'b0; tv[4].cyc = 8'd9;
    // T5 JZ not taken
    tv[5].prog = {8{HLT}};
    tv[5].prog[0] = ins(4'h1, 2'd0, 2'd0, 8'h01);
    tv[5].prog[1] = ins(4'h8, 2'd0, 2'd0, 8'h06);
    tv[5].prog[2] = ins(4'h1, 2'd1, 2'd0, 8'h07);
    tv[5].regs = {8'h00, 8'h00, 8'h07, 8'h01};
    tv[5].pc = 4'd3; tv[5].z = 1'b0; tv[5].c = 1'b0; tv[5].cyc = 8'd12;
    // T6 JMP forward and back
    tv[6].prog = {8{HLT}};
    tv[6].prog[0] = ins(4'h7, 2'd0, 2'd0, 8'h03);
    tv[6].prog[1] = ins(4'h1, 2'd0, 2'd0, 8'h01);
    tv[6].prog[3] = ins(4'h1, 2'd1, 2'd0, 8'h55);
    tv[6].prog[4] = ins(4'h7, 2'd0, 2'd0, 8'h02);
    tv[6].regs = {8'h00, 8'h00, 8'h55, 8'h00};
    tv[6].pc = 4'd2; tv[6].z = 1'b0; tv[6].c = 1'b0; tv[6].cyc = 8'd12;
    // T7 illegal opcode A is a NOP
    tv[7].prog = {8{HLT}};
    tv[7].prog[0] = ins(4'h1, 2'd0, 2'd0, 8'h11);
    tv[7].prog[1] = ins(4'hA, 2'd0, 2'd0, 8'h22);
    tv[7].regs = {8'h00, 8'h00, 8'h00, 8'h11};
    tv[7].pc = 4'd2; tv[7].z = 1'b0; tv[7].c = 1'b0; tv[7].cyc = 8'd9;
    // T8 opcode 9: JC with carry feature, illegal NOP without
    tv[8].prog = {8{HLT}};
    tv[8].prog[0] = ins(4'h1, 2'd0, 2'd0, 8'hFF);
    tv[8].prog[1] = ins(4'h1, 2'd1, 2'd0, 8'h01);
    tv[8].prog[2] = ins(4'h2, 2'd0, 2'd1, 8'h00);
    tv[8].prog[3] = ins(4'h9, 2'd0, 2'd0, 8'h06);
    tv[8].prog[4] = ins(4'h1, 2'd2, 2'd0, 8'h77);
`ifdef PARAM_CPU_CARRY_EN
    tv[8].regs = {8'h00, 8'h00, 8'h01, 8'h00};
    tv[8].pc = 4'd6; tv[8].z = 1'b1; tv[8].c = 1'b1; tv[8].cyc = 8'd15;
`else
    tv[8].regs = {8'h00, 8'h77, 8'h01, 8'h00};
    tv[8].pc = 4'd5; tv[8].z = 1'b0; tv[8].c = 1'b0; tv[8].cyc = 8'd18;
`endif

    // Reset state, observed while rst is still held
    #12;
    check("rst halted", 32'(halted), 32'd1);
    check("rst pc", 32'(pc), 32'd0);
    check("rst instruction", 32'(instruction), 32'd0);
    check("rst zero", 32'(zero_flag), 32'd0);
    check("rst carry", 32'(carry_flag), 32'd0);
    check("rst illegal", 32'(illegal), 32'd0);
    check_regs("rst", '0);
    do_reset();

    for (int t = 0; t < NV; t++) begin
      do_reset();
      img = {16{HLT}};
      for (int w = 0; w < 8; w++) img[w] = tv[t].prog[w];
      load(img);
      start_run();
      wait_halt(cyc);
      check($sformatf("t%0d cycles", t), 32'(cyc), 32'(tv[t].cyc));
      check($sformatf("t%0d halted", t), 32'(halted), 32'd1);
      check($sformatf("t%0d pc", t), 32'(pc), 32'(tv[t].pc));
      check($sformatf("t%0d zero", t), 32'(zero_flag), 32'(tv[t].z));
      check($sformatf("t%0d carry", t), 32'(carry_flag), 32'(tv[t].c));
      check_regs($sformatf("t%0d", t), tv[t].regs);
    end

    // Illegal pulse width and position (program still loaded from T8 -> reload T7)
    do_reset();
    img = {16{HLT}};
    for (int w = 0; w < 8; w++) img[w] = tv[7].prog[w];
    load(img);
    start_run();
    ill_cnt = 0; ill_at = -1; cyc = 0;
    while (!halted && cyc < 200) begin
      tick();
      cyc++;
      if (illegal) begin
        ill_cnt++;
        if (ill_at < 0) ill_at = cyc;
      end
    end
    check("illegal cycles", 32'(ill_cnt), 32'd1);
    check("illegal position", 32'(ill_at), 32'd5);

    // pc wrap via JMP at word 15
    do_reset();
    img = {16{NOP}};
    img[15] = ins(4'h7, 2'd0, 2'd0, 8'h02);
    load(img);
    start_run();
    repeat (45) tick();
    check("wrap jmp pc15", 32'(pc), 32'd15);
    repeat (3) tick();
    check("wrap jmp pc2", 32'(pc), 32'd2);
    check("wrap jmp running", 32'(halted), 32'd0);

    // pc wrap 15->0 with a NOP at word 15
    do_reset();
    img = {16{NOP}};
    load(img);
    start_run();
    repeat (48) tick();
    check("wrap nop pc0", 32'(pc), 32'd0);
    check("wrap nop running", 32'(halted), 32'd0);

    // prog_we while running is ignored; rst during EXECUTE of ADD aborts it
    do_reset();
    img = {16{HLT}};
    for (int w = 0; w < 8; w++) img[w] = tv[0].prog[w];
    load(img);
    start_run();
    tick();
    prog_we = 1'b1; prog_addr = 4'd3; prog_data = NOP;
    tick();
    prog_addr = 4'd0; prog_data = HLT;
    tick();
    prog_we = 1'b0;
    repeat (5) tick();
    dbg_sel = 2'd1;
    #1;
    check("pre-rst r1", 32'(dbg_data), 32'h03);
    check("pre-rst running", 32'(halted), 32'd0);
    rst = 1'b1;
    #1;
    check("mid-rst halted", 32'(halted), 32'd1);
    check("mid-rst pc", 32'(pc), 32'd0);
    check("mid-rst zero", 32'(zero_flag), 32'd0);
    check_regs("mid-rst", '0);
    tick();
    rst = 1'b0;
    tick();
    start_run();
    wait_halt(cyc);
    check("rerun cycles", 32'(cyc), 32'd12);
    check("rerun pc", 32'(pc), 32'd3);
    check("rerun zero", 32'(zero_flag), 32'd0);
    check_regs("rerun", {8'h00, 8'h00, 8'h03, 8'h08});

    // prog_we and start in the same HALT cycle: new word 0 is fetched
    do_reset();
    img = {16{HLT}};
    load(img);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = ins(4'h1, 2'd3, 2'd0, 8'h42);
    start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    wait_halt(cyc);
    check("same-cycle cycles", 32'(cyc), 32'd6);
    check("same-cycle pc", 32'(pc), 32'd1);
    check_regs("same-cycle", {8'h42, 8'h00, 8'h00, 8'h00});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_cpu.md
PARAM_CPU -- requirements
Module: param_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning register/ALU/immediate width.
REQ-002 SHALL have parameter NUM_REGS, default 4 (power of two, >=2), meaning general register count.
REQ-003 SHALL have parameter IMEM_DEPTH, default 16 (power of two), meaning instruction memory words.
REQ-004 SHALL derive PC_W=clog2(IMEM_DEPTH), RA_W=clog2(NUM_REGS), INSTR_W=4+2*RA_W+DATA_W; field order [opcode|rd|rs|imm], opcode in the MSBs.
REQ-005 SHALL have clk  input  1  single clock, rising edge.
REQ-006 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have start  input  1  leave HALT and begin execution at PC 0.
REQ-008 SHALL have prog_we / prog_addr / prog_data  input  1 / PC_W / INSTR_W  instruction memory write port.
REQ-009 SHALL have dbg_sel  input  RA_W  and  dbg_data  output  DATA_W  (combinational register readout).
REQ-010 SHALL have pc  output  PC_W, instruction  output  INSTR_W (latched instruction register), halted  output  1.
REQ-011 SHALL have zero_flag, carry_flag, illegal  outputs  1 each.

Function
REQ-012 SHALL run a state machine HALT -> FETCH -> DECODE -> EXECUTE -> FETCH; exactly 3 cycles per instruction.
REQ-013 FETCH SHALL latch imem[pc] into instruction; DECODE SHALL latch rd, rs, imm and operands; EXECUTE SHALL write results, update flags, and update pc.
REQ-014 Opcodes: 0 NOP; 1 LDI rd<=imm; 2 ADD rd<=rd+rs; 3 SUB rd<=rd-rs; 4 AND; 5 OR; 6 MOV rd<=rs; 7 JMP pc<=imm[PC_W-1:0]; 8 JZ jump if zero_flag; F HALT.
REQ-015 Arithmetic SHALL be modulo 2^DATA_W; zero_flag SHALL update on opcodes 1-6 only, set when the written result is 0.
REQ-016 Non-jump instructions SHALL set pc<=pc+1, wrapping from IMEM_DEPTH-1 to 0.
REQ-017 HALT SHALL keep pc pointing at the HALT word, assert halted, and return to state HALT.
REQ-018 Unassigned opcodes SHALL execute as NOP and pulse illegal high for exactly the EXECUTE cycle.
REQ-019 prog_we SHALL write imem only in state HALT; ignored otherwise.
REQ-020 start SHALL be honoured only in HALT (pc<=0, next state FETCH); ignored otherwise.
REQ-021 prog_we and start in the same HALT cycle: write commits that cycle; the following FETCH sees the new word.
REQ-022 halted SHALL be 1 exactly while in state HALT.

Reset
REQ-023 rst SHALL force immediately: state HALT, pc 0, instruction 0, all registers 0, zero_flag 0, carry_flag 0, illegal 0, halted 1.
REQ-024 Instruction memory SHALL NOT be cleared by rst; reset mid-instruction SHALL abort it with no register or flag write.

Configuration
REQ-025 Macro PARAM_CPU_CARRY_EN defined: ADD sets carry_flag to the carry-out, SUB sets it to the borrow; opcode 9 JC jumps to imm when carry_flag is 1; opcodes 1,4,5,6 leave carry_flag unchanged.
REQ-026 Macro undefined: carry_flag tied 0, opcode 9 is illegal per REQ-018.

Structure
REQ-027 Opcode constants, state encoding, and field-width functions SHALL live in shared package param_cpu_pkg.
REQ-028 ALU SHALL be sub-module param_cpu_alu (combinational: op, a, b -> result, zero, carry); register file and imem stay in param_cpu.

Verification (defaults: DATA_W=8, NUM_REGS=4, IMEM_DEPTH=16)
REQ-029 Load LDI r0,5; LDI r1,3; ADD r0,r1; HALT; pulse start -> r0=8, zero_flag=0, halted rises 12 cycles after start, pc=3.
REQ-030 LDI r0,0xFF; LDI r1,1; ADD r0,r1 -> r0=0x00, zero_flag=1, carry_flag=1 (with macro) or 0 (without).
REQ-031 LDI r0,0; JZ 6 -> pc=6 next FETCH; LDI r0,1; JZ 6 -> pc advances by 1.
REQ-032 15 NOPs then word 15 = JMP 2 -> pc wraps correctly; program with no HALT and word 15 = NOP wraps pc 15->0.
REQ-033 Assert rst during EXECUTE of ADD -> immediately halted=1, pc=0, registers 0; imem intact; rerun via start reproduces REQ-029.
REQ-034 prog_we while running -> imem unchanged; opcode 0xA executed -> illegal high exactly one cycle, registers unchanged.
